// File: rtl/rr_arbiter8_pkg.sv
// Shared types, constants and the round-robin winner search for rr_arbiter8.
package rr_arbiter8_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int NUM_REQ = 8;
   localparam int ID_W    = 3;

   // Returns {found, idx}. The search starts one past `last` and wraps, so
   // `last` is examined at the very end and a lone requester still wins.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [ID_W-1:0]    last);
      logic            found;
      logic [ID_W-1:0] idx;
      logic [ID_W-1:0] cand;
      found = 1'b0;
      idx   = last;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = last + ID_W'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/rr_arbiter8_decoder3x8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decoder3x8 (
   input  logic [2:0] A,
   input  logic       en,
   output logic [7:0] Y
);

   // Decode A to a single set bit only while enabled.
   always_comb begin
      Y = '0;
      if (en) begin
         Y[A] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: one shared slot, eight requesters, bounded hold time.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; next edge grants the round-robin winner if any req
// BUSY  | owner gnt_id holds the slot until done, withdrawal or hold limit
module rr_arbiter8
   import rr_arbiter8_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic                 done,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [ID_W-1:0]      gnt_id,
   output logic                 gnt_valid,
   output logic                 timeout
);

   state_t              r_state;
   logic [ID_W-1:0]     r_gnt_id;
   logic                r_gnt_valid;
   logic [ID_W-1:0]     r_last;
   logic [HOLD_W-1:0]   r_hold;
   logic                r_timeout;

   state_t              w_state_nxt;
   logic [ID_W-1:0]     w_gnt_id_nxt;
   logic                w_gnt_valid_nxt;
   logic [ID_W-1:0]     w_last_nxt;
   logic [HOLD_W-1:0]   w_hold_nxt;
   logic                w_timeout_nxt;

   logic [ID_W:0]       w_pick;
   logic                w_withdraw;
   logic                w_hold_max;

   assign w_pick     = rr_pick(req, r_last);
   assign w_withdraw = ~req[r_gnt_id];
   assign w_hold_max = (r_hold == HOLD_W'(MAX_HOLD));

   // State and grant registers; reset drops any grant without a handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_gnt_id    <= '0;
         r_gnt_valid <= 1'b0;
         r_last      <= ID_W'(NUM_REQ - 1);
         r_hold      <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_gnt_id    <= w_gnt_id_nxt;
         r_gnt_valid <= w_gnt_valid_nxt;
         r_last      <= w_last_nxt;
         r_hold      <= w_hold_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

   // Grant in IDLE, release in BUSY; timeout only when the limit alone ends it.
   always_comb begin
      w_state_nxt     = r_state;
      w_gnt_id_nxt    = r_gnt_id;
      w_gnt_valid_nxt = r_gnt_valid;
      w_last_nxt      = r_last;
      w_hold_nxt      = r_hold;
      w_timeout_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick[ID_W]) begin
               w_state_nxt     = BUSY;
               w_gnt_id_nxt    = w_pick[ID_W-1:0];
               w_gnt_valid_nxt = 1'b1;
               w_hold_nxt      = HOLD_W'(1);
            end
         end
         BUSY: begin
            if (done || w_withdraw || w_hold_max) begin
               w_state_nxt     = IDLE;
               w_gnt_valid_nxt = 1'b0;
               w_last_nxt      = r_gnt_id;
               w_hold_nxt      = '0;
               w_timeout_nxt   = w_hold_max && !done && !w_withdraw;
            end else begin
               w_hold_nxt = r_hold + HOLD_W'(1);
            end
         end
         default: begin
            w_state_nxt     = IDLE;
            w_gnt_valid_nxt = 1'b0;
            w_hold_nxt      = '0;
         end
      endcase
   end

   assign gnt_id    = r_gnt_id;
   assign gnt_valid = r_gnt_valid;
   assign timeout   = r_timeout;

   decoder3x8 u_dec (
      .A  (r_gnt_id),
      .en (r_gnt_valid),
      .Y  (gnt)
   );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed vector table plus randomized run against
// a cycle-level reference model of the arbitration rules.
module tb_rr_arbiter8;

   localparam int MAXH = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit  m_valid;
   int  m_id;
   int  m_last;
   int  m_hold;
   bit  m_to;

   typedef struct {
      logic       rst_n;
      logic [7:0] req;
      logic       done;
      logic [7:0] gnt;
      logic       valid;
      logic       to;
   } vec_t;

   vec_t vecs[$];

   rr_arbiter8 #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add(input logic r, input logic [7:0] q, input logic d,
                               input logic [7:0] g, input logic v, input logic t);
      vec_t x;
      x.rst_n = r; x.req = q; x.done = d; x.gnt = g; x.valid = v; x.to = t;
      vecs.push_back(x);
   endfunction

   // One clock of the arbitration rules, from the sampled inputs.
   function automatic void model_step(input logic r, input logic [7:0] q, input logic d);
      bit rel;
      bit wd;
      int idx;
      if (!r) begin
         m_valid = 0; m_id = 0; m_last = 7; m_hold = 0; m_to = 0;
      end else if (!m_valid) begin
         m_to = 0;
         for (int k = 1; k <= 8; k++) begin
            idx = (m_last + k) % 8;
            if (q[idx]) begin
               m_valid = 1; m_id = idx; m_hold = 1;
               break;
            end
         end
      end else begin
         wd  = !q[m_id];
         rel = d || wd || (m_hold == MAXH);
         if (rel) begin
            m_to    = (m_hold == MAXH) && !d && !wd;
            m_valid = 0;
            m_last  = m_id;
            m_hold  = 0;
         end else begin
            m_to   = 0;
            m_hold = m_hold + 1;
         end
      end
   endfunction

   task automatic step(input logic r, input logic [7:0] q, input logic d);
      logic [7:0] eg;
      rst_n = r; req = q; done = d;
      @(posedge clk);
      model_step(r, q, d);
      #1;
      eg = m_valid ? (8'h01 << m_id) : 8'h00;
      chk("model_gnt", gnt, eg);
      chk("model_gnt_valid", gnt_valid, m_valid);
      chk("model_gnt_id", gnt_id, m_id[2:0]);
      chk("model_timeout", timeout, m_to);
      chk("onehot_rule", (gnt_valid ? $onehot(gnt) : (gnt == 8'h00)), 1);
   endtask

   initial begin
      rst_n = 1'b0; req = '0; done = 1'b0;
      m_valid = 0; m_id = 0; m_last = 7; m_hold = 0; m_to = 0;

      // lone requester 0, done release, re-grant after one idle cycle
      add(0, 8'h00, 0, 8'h00, 0, 0);
      add(1, 8'h01, 0, 8'h01, 1, 0);
      add(1, 8'h01, 1, 8'h00, 0, 0);
      add(1, 8'h01, 0, 8'h01, 1, 0);
      add(1, 8'h01, 1, 8'h00, 0, 0);
      // all requesting: rotation 0..7 then 0
      add(0, 8'hFF, 0, 8'h00, 0, 0);
      for (int i = 0; i < 8; i++) begin
         add(1, 8'hFF, 0, 8'(1 << i), 1, 0);
         add(1, 8'hFF, 1, 8'h00, 0, 0);
      end
      add(1, 8'hFF, 0, 8'h01, 1, 0);
      add(1, 8'hFF, 1, 8'h00, 0, 0);
      // last=5, then ids 4 and 7 requesting: 7, 4, 7
      add(0, 8'h00, 0, 8'h00, 0, 0);
      add(1, 8'h20, 0, 8'h20, 1, 0);
      add(1, 8'h20, 1, 8'h00, 0, 0);
      add(1, 8'h90, 0, 8'h80, 1, 0);
      add(1, 8'h90, 1, 8'h00, 0, 0);
      add(1, 8'h90, 0, 8'h10, 1, 0);
      add(1, 8'h90, 1, 8'h00, 0, 0);
      add(1, 8'h90, 0, 8'h80, 1, 0);
      // hold limit: 4 granted cycles, timeout pulse, re-grant
      add(0, 8'h00, 0, 8'h00, 0, 0);
      for (int i = 0; i < MAXH; i++) add(1, 8'h08, 0, 8'h08, 1, 0);
      add(1, 8'h08, 0, 8'h00, 0, 1);
      add(1, 8'h08, 0, 8'h08, 1, 0);
      // withdrawal of id 2, pending id 6 granted next
      add(0, 8'h00, 0, 8'h00, 0, 0);
      add(1, 8'h04, 0, 8'h04, 1, 0);
      add(1, 8'h40, 0, 8'h00, 0, 0);
      add(1, 8'h40, 0, 8'h40, 1, 0);
      // done on the limit cycle: release without timeout
      for (int i = 1; i < MAXH; i++) add(1, 8'h40, 0, 8'h40, 1, 0);
      add(1, 8'h40, 1, 8'h00, 0, 0);
      // reset mid-grant, then all requesting starts at id 0
      add(0, 8'h00, 0, 8'h00, 0, 0);
      add(1, 8'h20, 0, 8'h20, 1, 0);
      add(1, 8'h20, 0, 8'h20, 1, 0);
      add(0, 8'h20, 0, 8'h00, 0, 0);
      add(1, 8'hFF, 0, 8'h01, 1, 0);

      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].req, vecs[i].done);
         chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
         chk($sformatf("vec%0d_valid", i), gnt_valid, vecs[i].valid);
         chk($sformatf("vec%0d_timeout", i), timeout, vecs[i].to);
      end

      // randomized traffic against the model
      begin
         logic [7:0] rq;
         logic       rr;
         logic       dd;
         rq = 8'($urandom);
         for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) rq = 8'($urandom);
            if ($urandom_range(0, 9) == 0) rq = 8'h01 << $urandom_range(0, 7);
            dd = ($urandom_range(0, 4) == 0);
            rr = ($urandom_range(0, 99) != 0);
            step(rr, rq, dd);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource slot among 8 requesters.
- Registers a 3-bit owner index and drives a one-hot grant vector through the team's 3-to-8 decoder, with enable = grant valid.
- Holds the grant until the owner releases or a hold-timeout fires.
- Sits in front of any shared datapath resource whose select lines are decoder-driven.

Parameters:
- MAX_HOLD, 16, maximum cycles one owner may hold the grant before forced release (legal range 1..255).
- HOLD_W, 8, width of the hold counter (must satisfy 2^HOLD_W > MAX_HOLD).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- req  in  8  request vector, bit i = requester i; level-sensitive.
- done  in  1  release strobe from the current owner; ignored when gnt_valid=0.
- gnt  out  8  one-hot grant, decoder output of gnt_id enabled by gnt_valid; all-zero when idle.
- gnt_id  out  3  registered owner index.
- gnt_valid  out  1  registered; 1 while a grant is held.
- timeout  out  1  one-cycle pulse in the cycle a forced release is registered.

Behaviour:
- Reset (rst_n=0 at a rising edge) forces these values:
  - gnt_valid=0, gnt_id=0, gnt=8'h00, timeout=0, hold counter=0, state=IDLE.
  - Priority pointer last=3'd7, so requester 0 wins first.
  - Reset mid-grant drops the grant on that same edge, with no release handshake.
- FSM states:
  - IDLE: if req != 0, pick the winner, set gnt_id=winner, gnt_valid=1, hold=1, go to BUSY. Otherwise stay.
  - BUSY: a release condition is any of:
    - done=1;
    - req[gnt_id]=0 (owner withdrew);
    - hold==MAX_HOLD.
  - On release: gnt_valid=0, last=gnt_id, hold=0, go to IDLE. Otherwise hold increments.
  - timeout=1 only when release is caused by hold==MAX_HOLD and neither done nor owner withdrawal is present that cycle.
- Winner selection (combinational, used only in IDLE):
  - Search indices last+1, last+2, … mod 8, wrapping 7→0.
  - The first i with req[i]=1 wins.
  - last itself is searched last, so a lone requester is always re-granted.
- Latency:
  - req seen in IDLE at edge N → gnt valid after edge N.
  - Release seen at edge M → gnt=0 after M; earliest new grant after M+1.
  - This gives a mandatory one-cycle idle gap between owners.
- Grant width rules:
  - gnt is exactly one-hot when gnt_valid=1 and zero otherwise; never multi-hot.
  - gnt_id is stable for the whole grant. It keeps its last value in IDLE, but consumers qualify it with gnt_valid.
- Simultaneous events:
  - done and timeout in the same cycle: release, timeout=0.
  - New requests arriving during BUSY are not seen until IDLE.
  - req changes in IDLE on the deciding edge use the sampled value at that edge.
- Hold counter saturation: the counter never exceeds MAX_HOLD. With MAX_HOLD=1, every grant lasts exactly one cycle.

Decomposition:
- Shared package contents:
  - State enum: IDLE=1'b0, BUSY=1'b1.
  - Constants: NUM_REQ=8, ID_W=3.
  - A function rr_pick(req, last) returning {found, idx}.
- Sub-module: the existing decoder3x8 instantiated once, with A=gnt_id, en=gnt_valid, Y=gnt. No other sub-modules.

Test Plan:
1. Reset then req=8'h01 held: gnt=8'h01, gnt_id=0 one cycle after req; assert done → gnt=0 next cycle, re-grant gnt=8'h01 the cycle after.
2. req=8'hFF continuous, done pulsed each grant: grant order is ids 0,1,2,…,7,0, with gnt=0 between each.
3. req=8'h90 (ids 4 and 7) after id 5 was last: grant goes to 7 first, then 4, then 7.
4. MAX_HOLD=4, req=8'h08 held, no done: gnt=8'h08 for exactly 4 cycles, timeout=1 on the releasing cycle, then re-grant to id 3 after one idle cycle.
5. Owner withdrawal: granted id 2, drop req[2] with done=0 → gnt=0 next cycle, timeout=0; pending req[6] granted one cycle later.
6. Reset mid-grant: id 5 holding, rst_n=0 for one edge → gnt=8'h00, gnt_valid=0 immediately after that edge; with req=8'hFF on rst_n release, first grant is id 0.
